mem_req_master: RTL and testbench

Bus initiator for the memory-mapped peripheral request/response interface that the timer and similar peripherals respond to. It accepts one command at a time from a core-side valid/ready port and issues single-cycle requests. Supported commands are read, write, masked read-modify-write, and one-cycle bit pulse (toggle, then restore). Typical use is the load/store path or a debug/boot sequencer driving peripheral control registers.

---
 rtl/mem_req_master_pkg.sv | 36 +++
 rtl/mem_req_master_if.sv | 40 ++++
 rtl/mem_req_merge.sv | 16 +
 rtl/mem_req_master.sv | 165 ++++++++++++++++
 tb/tb_mem_req_master.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_req_master_pkg.sv
// rtl/mem_req_master_pkg.sv - shared widths, bus size/status codes, op and state encodings
package mem_req_master_pkg;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_WORD_W  = 32;
  localparam int MEM_COUNT_W = 2;
  localparam int MEM_CODE_W  = 2;

  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 2'd0;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 2'd1;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 2'd2;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd3;

  localparam logic [MEM_CODE_W-1:0] MEM_CODE_OK      = 2'd0;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_ERR     = 2'd1;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_INVALID = 2'd2;

  typedef enum logic [1:0] {
    MEM_OP_READ  = 2'd0,
    MEM_OP_WRITE = 2'd1,
    MEM_OP_RMW   = 2'd2,
    MEM_OP_PULSE = 2'd3
  } mem_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_CHK,
    ST_WR,
    ST_WR_CHK,
    ST_RESTORE,
    ST_RESTORE_CHK,
    ST_DONE
  } mem_state_e;

endpackage

// File: rtl/mem_req_master_if.sv
// rtl/mem_req_master_if.sv - core command/response port and peripheral request/response bus
interface mem_req_master_if
  import mem_req_master_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WORD_W = DEF_WORD_W
) ();

  logic                   i_cmd_valid;
  logic                   o_cmd_ready;
  logic [1:0]             i_cmd_op;
  logic [ADDR_W-1:0]      i_cmd_addr;
  logic [WORD_W-1:0]      i_cmd_data;
  logic [WORD_W-1:0]      i_cmd_mask;
  logic [MEM_COUNT_W-1:0] i_cmd_count;
  logic                   o_rsp_valid;
  logic [WORD_W-1:0]      o_rsp_data;
  logic [MEM_CODE_W-1:0]  o_rsp_code;
  logic [ADDR_W-1:0]      o_req_addr;
  logic [WORD_W-1:0]      o_req_wr_data;
  logic                   o_req_wr_en;
  logic [MEM_COUNT_W-1:0] o_req_count;
  logic [WORD_W-1:0]      i_res_rd_data;
  logic [MEM_CODE_W-1:0]  i_res_code;

  modport master (
    input  i_cmd_valid, i_cmd_op, i_cmd_addr, i_cmd_data, i_cmd_mask, i_cmd_count,
    input  i_res_rd_data, i_res_code,
    output o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_code,
    output o_req_addr, o_req_wr_data, o_req_wr_en, o_req_count
  );

  modport slave (
    output i_cmd_valid, i_cmd_op, i_cmd_addr, i_cmd_data, i_cmd_mask, i_cmd_count,
    output i_res_rd_data, i_res_code,
    input  o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_code,
    input  o_req_addr, o_req_wr_data, o_req_wr_en, o_req_count
  );

endinterface

// File: rtl/mem_req_merge.sv
// rtl/mem_req_merge.sv - write data for RMW (masked merge) and PULSE (toggle) commands
module mem_req_merge
  import mem_req_master_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  mem_op_e           op,
  input  logic [WORD_W-1:0] rd,
  input  logic [WORD_W-1:0] data,
  input  logic [WORD_W-1:0] mask,
  output logic [WORD_W-1:0] wr_data
);

  assign wr_data = (op == MEM_OP_PULSE) ? (rd ^ mask) : ((rd & ~mask) | (data & mask));

endmodule

// File: rtl/mem_req_master.sv
// rtl/mem_req_master.sv - single-command bus initiator: read, write, masked RMW, bit pulse
module mem_req_master
  import mem_req_master_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WORD_W = DEF_WORD_W
) (
  input logic              clk,
  input logic              aresetn,
  mem_req_master_if.master bus
);

  mem_state_e             state_q, state_d;
  mem_op_e                op_q, op_d, cmd_op;
  logic [WORD_W-1:0]      data_q, data_d, mask_q, mask_d, rd_q, rd_d;
  logic [MEM_COUNT_W-1:0] count_q, count_d;
  logic [MEM_CODE_W-1:0]  err_q, err_d, first_code;
  logic [ADDR_W-1:0]      req_addr_q, req_addr_d;
  logic [WORD_W-1:0]      req_wr_data_q, req_wr_data_d;
  logic                   req_wr_en_q, req_wr_en_d;
  logic [MEM_COUNT_W-1:0] req_count_q, req_count_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [WORD_W-1:0]      rsp_data_q, rsp_data_d;
  logic [MEM_CODE_W-1:0]  rsp_code_q, rsp_code_d;
  logic [WORD_W-1:0]      merge_data;
  logic                   direct_write;

  assign cmd_op = mem_op_e'(bus.i_cmd_op);
  // A full-mask RMW overwrites every bit, so the read is pointless.
  assign direct_write = (cmd_op == MEM_OP_WRITE) || (cmd_op == MEM_OP_RMW && (&bus.i_cmd_mask));
  assign first_code = (err_q != MEM_CODE_OK) ? err_q : bus.i_res_code;

  mem_req_merge #(.WORD_W(WORD_W)) u_merge (
    .op      (op_q),
    .rd      (bus.i_res_rd_data),
    .data    (data_q),
    .mask    (mask_q),
    .wr_data (merge_data)
  );

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    data_d        = data_q;
    mask_d        = mask_q;
    count_d       = count_q;
    rd_d          = rd_q;
    err_d         = err_q;
    req_addr_d    = req_addr_q;
    req_wr_data_d = req_wr_data_q;
    req_wr_en_d   = 1'b0;
    req_count_d   = MEM_COUNT_NONE;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data_q;
    rsp_code_d    = rsp_code_q;
    case (state_q)
      ST_IDLE: if (bus.i_cmd_valid) begin
        op_d    = cmd_op;
        data_d  = bus.i_cmd_data;
        mask_d  = bus.i_cmd_mask;
        count_d = bus.i_cmd_count;
        rd_d    = '0;
        err_d   = MEM_CODE_OK;
        if (bus.i_cmd_count == MEM_COUNT_NONE) begin
          state_d     = ST_DONE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_code_d  = MEM_CODE_INVALID;
        end else if (direct_write) begin
          state_d       = ST_WR;
          req_addr_d    = bus.i_cmd_addr;
          req_wr_data_d = bus.i_cmd_data;
          req_wr_en_d   = 1'b1;
          req_count_d   = bus.i_cmd_count;
        end else begin
          state_d     = ST_RD;
          req_addr_d  = bus.i_cmd_addr;
          req_count_d = bus.i_cmd_count;
        end
      end
      ST_RD: state_d = ST_RD_CHK;
      ST_RD_CHK: begin
        rd_d = bus.i_res_rd_data;
        if (op_q == MEM_OP_READ || bus.i_res_code != MEM_CODE_OK) begin
          state_d     = ST_DONE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = bus.i_res_rd_data;
          rsp_code_d  = bus.i_res_code;
        end else begin
          state_d       = ST_WR;
          req_wr_data_d = merge_data;
          req_wr_en_d   = 1'b1;
          req_count_d   = count_q;
        end
      end
      ST_WR: begin
        // Restore follows immediately so the toggled bits live for one cycle only.
        if (op_q == MEM_OP_PULSE) begin
          state_d       = ST_RESTORE;
          req_wr_data_d = rd_q;
          req_wr_en_d   = 1'b1;
          req_count_d   = count_q;
        end else begin
          state_d = ST_WR_CHK;
        end
      end
      ST_WR_CHK, ST_RESTORE_CHK: begin
        state_d     = ST_DONE;
        rsp_valid_d = 1'b1;
        rsp_data_d  = rd_q;
        rsp_code_d  = first_code;
      end
      ST_RESTORE: begin
        err_d   = first_code;
        state_d = ST_RESTORE_CHK;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= ST_IDLE;
      op_q          <= MEM_OP_READ;
      data_q        <= '0;
      mask_q        <= '0;
      count_q       <= MEM_COUNT_NONE;
      rd_q          <= '0;
      err_q         <= MEM_CODE_OK;
      req_addr_q    <= '0;
      req_wr_data_q <= '0;
      req_wr_en_q   <= 1'b0;
      req_count_q   <= MEM_COUNT_NONE;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_code_q    <= MEM_CODE_OK;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      data_q        <= data_d;
      mask_q        <= mask_d;
      count_q       <= count_d;
      rd_q          <= rd_d;
      err_q         <= err_d;
      req_addr_q    <= req_addr_d;
      req_wr_data_q <= req_wr_data_d;
      req_wr_en_q   <= req_wr_en_d;
      req_count_q   <= req_count_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_code_q    <= rsp_code_d;
    end
  end

  assign bus.o_cmd_ready   = (state_q == ST_IDLE);
  assign bus.o_rsp_valid   = rsp_valid_q;
  assign bus.o_rsp_data    = rsp_data_q;
  assign bus.o_rsp_code    = rsp_code_q;
  assign bus.o_req_addr    = req_addr_q;
  assign bus.o_req_wr_data = req_wr_data_q;
  assign bus.o_req_wr_en   = req_wr_en_q;
  assign bus.o_req_count   = req_count_q;

endmodule

// File: tb/tb_mem_req_master.sv
// tb/tb_mem_req_master.sv - self-checking bench for mem_req_master with a registered RAM/timer responder
module tb_mem_req_master;
  import mem_req_master_pkg::*;

  localparam int AW = 16;
  localparam int WW = 32;

  typedef struct {
    mem_op_e    op;
    logic [15:0] addr;
    logic [31:0] data;
    logic [31:0] mask;
    logic [1:0]  count;
    logic        pre_en;
    logic [31:0] pre_val;
    logic [31:0] exp_data;
    logic [1:0]  exp_code;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_w0;
    logic [31:0] exp_w1;
    int          exp_strobe;
    logic        chk_mem;
    logic [31:0] exp_mem;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  code;
  } exp_t;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  mem_req_master_if #(.ADDR_W(AW), .WORD_W(WW)) bus ();

  mem_req_master #(.ADDR_W(AW), .WORD_W(WW)) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  exp_t exp_q[$];

  // Responder: 64-word RAM below 0x100, error above; garbage when no request.
  logic [31:0] mem [0:63];
  logic        pre_en = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    if (bus.o_req_count != MEM_COUNT_NONE) begin
      if (bus.o_req_addr < 16'h0100) begin
        bus.i_res_rd_data <= mem[bus.o_req_addr[7:2]];
        bus.i_res_code    <= MEM_CODE_OK;
        if (bus.o_req_wr_en) mem[bus.o_req_addr[7:2]] <= bus.o_req_wr_data;
      end else begin
        bus.i_res_rd_data <= '0;
        bus.i_res_code    <= MEM_CODE_ERR;
      end
    end else begin
      bus.i_res_rd_data <= 32'h5a5a5a5a;
      bus.i_res_code    <= MEM_CODE_ERR;
    end
  end

  logic [31:0] wr_log[$];
  int rd_cnt = 0;
  int strobe_cnt = 0;
  always @(negedge clk) begin
    if (aresetn && bus.o_req_count != MEM_COUNT_NONE) begin
      if (bus.o_req_wr_en) begin
        wr_log.push_back(bus.o_req_wr_data);
        if (bus.o_req_addr == 16'h0 && bus.o_req_wr_data[1]) strobe_cnt = strobe_cnt + 1;
      end else begin
        rd_cnt = rd_cnt + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no response within bound", nm);
  endtask

  task automatic drive_cmd(input vec_t v);
    bus.i_cmd_op    = v.op;
    bus.i_cmd_addr  = v.addr;
    bus.i_cmd_data  = v.data;
    bus.i_cmd_mask  = v.mask;
    bus.i_cmd_count = v.count;
  endtask

  task automatic preload(input logic [15:0] addr, input logic [31:0] val);
    @(negedge clk);
    pre_en  = 1'b1;
    pre_idx = addr[7:2];
    pre_val = val;
    @(negedge clk);
    pre_en  = 1'b0;
  endtask

  task automatic check_rsp(input string nm);
    exp_t e;
    if (exp_q.size() == 0) begin
      fail({nm, "_unexpected_rsp"});
    end else begin
      e = exp_q.pop_front();
      chk({nm, "_data"}, 64'(bus.o_rsp_data), 64'(e.data));
      chk({nm, "_code"}, 64'(bus.o_rsp_code), 64'(e.code));
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int wr0, rd0, st0, lat;
    logic got;
    string nm;
    nm = $sformatf("v%0d", idx);
    if (v.pre_en) preload(v.addr, v.pre_val);
    @(negedge clk);
    wr0 = wr_log.size();
    rd0 = rd_cnt;
    st0 = strobe_cnt;
    chk({nm, "_ready"}, 64'(bus.o_cmd_ready), 64'd1);
    drive_cmd(v);
    bus.i_cmd_valid = 1'b1;
    exp_q.push_back('{v.exp_data, v.exp_code});
    @(posedge clk);
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
    lat = 1;
    got = 1'b0;
    while (!got && lat < 20) begin
      if (bus.o_rsp_valid) got = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    if (!got) begin
      fail({nm, "_rsp"});
      exp_q.delete();
    end else begin
      check_rsp(nm);
      chk({nm, "_lat"}, 64'(lat), 64'(v.exp_lat));
    end
    chk({nm, "_nrd"}, 64'(rd_cnt - rd0), 64'(v.exp_rd));
    chk({nm, "_nwr"}, 64'(wr_log.size() - wr0), 64'(v.exp_wr));
    if (v.exp_wr >= 1 && wr_log.size() > wr0)     chk({nm, "_w0"}, 64'(wr_log[wr0]), 64'(v.exp_w0));
    if (v.exp_wr >= 2 && wr_log.size() > wr0 + 1) chk({nm, "_w1"}, 64'(wr_log[wr0+1]), 64'(v.exp_w1));
    chk({nm, "_strobe"}, 64'(strobe_cnt - st0), 64'(v.exp_strobe));
    @(negedge clk);
    chk({nm, "_pulse_end"}, 64'(bus.o_rsp_valid), 64'd0);
    chk({nm, "_hold"}, 64'(bus.o_rsp_data), 64'(v.exp_data));
    if (v.chk_mem) chk({nm, "_mem"}, 64'(mem[v.addr[7:2]]), 64'(v.exp_mem));
  endtask

  task automatic run_b2b();
    vec_t c[3];
    int i, lowcnt, cyc, wr0, rd0;
    logic r;
    c[0] = '{MEM_OP_WRITE, 16'h10, 32'h11, 32'h0, MEM_COUNT_WORD, 1'b0, 32'h0,
             32'h0, MEM_CODE_OK, 3, 0, 1, 32'h11, 32'h0, 0, 1'b0, 32'h0};
    c[1] = '{MEM_OP_READ, 16'h10, 32'h0, 32'h0, MEM_COUNT_WORD, 1'b0, 32'h0,
             32'h11, MEM_CODE_OK, 3, 1, 0, 32'h0, 32'h0, 0, 1'b0, 32'h0};
    c[2] = '{MEM_OP_READ, 16'h14, 32'h0, 32'h0, MEM_COUNT_NONE, 1'b0, 32'h0,
             32'h0, MEM_CODE_INVALID, 1, 0, 0, 32'h0, 32'h0, 0, 1'b0, 32'h0};
    @(negedge clk);
    wr0 = wr_log.size();
    rd0 = rd_cnt;
    drive_cmd(c[0]);
    bus.i_cmd_valid = 1'b1;
    i = 0;
    lowcnt = 0;
    cyc = 0;
    while ((i < 3 || exp_q.size() > 0) && cyc < 60) begin
      if (bus.o_rsp_valid) check_rsp($sformatf("b2b_rsp%0d", i));
      r = bus.o_cmd_ready;
      if (r && i < 3) exp_q.push_back('{c[i].exp_data, c[i].exp_code});
      else if (!r) lowcnt++;
      @(negedge clk);
      cyc++;
      if (r && i < 3) begin
        i++;
        if (i < 3) drive_cmd(c[i]);
        else bus.i_cmd_valid = 1'b0;
      end
    end
    if (cyc >= 60) begin
      fail("b2b_done");
      exp_q.delete();
      bus.i_cmd_valid = 1'b0;
    end
    chk("b2b_ready_low", 64'(lowcnt), 64'd7);
    chk("b2b_nwr", 64'(wr_log.size() - wr0), 64'd1);
    chk("b2b_nrd", 64'(rd_cnt - rd0), 64'd1);
  endtask

  task automatic run_reset_mid_pulse();
    vec_t v;
    int n, seen;
    v = '{MEM_OP_PULSE, 16'h0, 32'h0, 32'h4, MEM_COUNT_WORD, 1'b1, 32'h1,
          32'h0, MEM_CODE_OK, 6, 1, 2, 32'h5, 32'h1, 0, 1'b0, 32'h0};
    preload(v.addr, v.pre_val);
    @(negedge clk);
    drive_cmd(v);
    bus.i_cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
    n = 0;
    while (!bus.o_req_wr_en && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) fail("rst_wait_wr");
    chk("rst_pre_wr_data", 64'(bus.o_req_wr_data), 64'h5);
    #2;
    aresetn = 1'b0;
    #1;
    chk("rst_count", 64'(bus.o_req_count), 64'(MEM_COUNT_NONE));
    chk("rst_wr_en", 64'(bus.o_req_wr_en), 64'd0);
    chk("rst_ready", 64'(bus.o_cmd_ready), 64'd1);
    chk("rst_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
    @(negedge clk);
    aresetn = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.o_rsp_valid || bus.o_req_count != MEM_COUNT_NONE) seen++;
    end
    chk("rst_quiet_after", 64'(seen), 64'd0);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{MEM_OP_WRITE, 16'h8, 32'hdeadbeef, 32'h0, MEM_COUNT_WORD, 1'b0, 32'h0,
                32'h0, MEM_CODE_OK, 3, 0, 1, 32'hdeadbeef, 32'h0, 0, 1'b1, 32'hdeadbeef};
    vecs[1] = '{MEM_OP_READ, 16'h8, 32'h0, 32'h0, MEM_COUNT_WORD, 1'b0, 32'h0,
                32'hdeadbeef, MEM_CODE_OK, 3, 1, 0, 32'h0, 32'h0, 0, 1'b0, 32'h0};
    vecs[2] = '{MEM_OP_RMW, 16'h0, 32'h5, 32'hf, MEM_COUNT_WORD, 1'b1, 32'ha0a0a0aa,
                32'ha0a0a0aa, MEM_CODE_OK, 5, 1, 1, 32'ha0a0a0a5, 32'h0, 0, 1'b1, 32'ha0a0a0a5};
    vecs[3] = '{MEM_OP_RMW, 16'h4, 32'h12345678, 32'hffffffff, MEM_COUNT_WORD, 1'b1, 32'hffff0000,
                32'h0, MEM_CODE_OK, 3, 0, 1, 32'h12345678, 32'h0, 0, 1'b1, 32'h12345678};
    vecs[4] = '{MEM_OP_PULSE, 16'h0, 32'h0, 32'h2, MEM_COUNT_BYTE, 1'b1, 32'h1,
                32'h1, MEM_CODE_OK, 6, 1, 2, 32'h3, 32'h1, 1, 1'b1, 32'h1};
    vecs[5] = '{MEM_OP_READ, 16'h100, 32'h0, 32'h0, MEM_COUNT_WORD, 1'b0, 32'h0,
                32'h0, MEM_CODE_ERR, 3, 1, 0, 32'h0, 32'h0, 0, 1'b0, 32'h0};
    vecs[6] = '{MEM_OP_RMW, 16'h100, 32'h5, 32'hf, MEM_COUNT_WORD, 1'b0, 32'h0,
                32'h0, MEM_CODE_ERR, 3, 1, 0, 32'h0, 32'h0, 0, 1'b0, 32'h0};
    vecs[7] = '{MEM_OP_PULSE, 16'h100, 32'h0, 32'h1, MEM_COUNT_BYTE, 1'b0, 32'h0,
                32'h0, MEM_CODE_ERR, 3, 1, 0, 32'h0, 32'h0, 0, 1'b0, 32'h0};
    vecs[8] = '{MEM_OP_READ, 16'h8, 32'h0, 32'h0, MEM_COUNT_NONE, 1'b0, 32'h0,
                32'h0, MEM_CODE_INVALID, 1, 0, 0, 32'h0, 32'h0, 0, 1'b0, 32'h0};
    vecs[9] = '{MEM_OP_WRITE, 16'h104, 32'hcafef00d, 32'h0, MEM_COUNT_WORD, 1'b0, 32'h0,
                32'h0, MEM_CODE_ERR, 3, 0, 1, 32'hcafef00d, 32'h0, 0, 1'b0, 32'h0};

    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_op    = '0;
    bus.i_cmd_addr  = '0;
    bus.i_cmd_data  = '0;
    bus.i_cmd_mask  = '0;
    bus.i_cmd_count = MEM_COUNT_NONE;
    repeat (3) @(negedge clk);
    chk("reset_count", 64'(bus.o_req_count), 64'(MEM_COUNT_NONE));
    chk("reset_wr_en", 64'(bus.o_req_wr_en), 64'd0);
    chk("reset_addr", 64'(bus.o_req_addr), 64'd0);
    chk("reset_wr_data", 64'(bus.o_req_wr_data), 64'd0);
    chk("reset_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
    chk("reset_rsp_data", 64'(bus.o_rsp_data), 64'd0);
    chk("reset_rsp_code", 64'(bus.o_rsp_code), 64'(MEM_CODE_OK));
    chk("reset_ready", 64'(bus.o_cmd_ready), 64'd1);
    aresetn = 1'b1;

    for (int k = 0; k < 10; k++) run_vec(vecs[k], k);
    run_b2b();
    run_reset_mid_pulse();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
